ifetch_stage: RTL and testbench

//  Instruction-fetch stage; consumer end of the EXM branch-redirect bus (br_bus = {pre_fail, jump_target}).

---
 rtl/ifetch_stage_if.sv | 25 ++
 rtl/ifetch_stage.sv | 98 +++++++++
 tb/tb_ifetch_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ifetch_stage_if.sv
// Fetch-stage port bundle: EXM redirect in, ID handoff out, instruction SRAM request/response.
// Handshake: the fs_to_ds_bus word transfers in any cycle where fs_to_ds_valid && ds_allowin;
// valid may be withdrawn without a transfer only when br_bus[32] (redirect) kills it.
interface ifetch_stage_if #(
  parameter int BR_BUS_WD       = 33,
  parameter int FS_TO_DS_BUS_WD = 65
);
  logic                       ds_allowin;
  logic [BR_BUS_WD-1:0]       br_bus;
  logic                       fs_to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
  logic                       inst_sram_en;
  logic [31:0]                inst_sram_addr;
  logic [31:0]                inst_sram_rdata;

  modport master (
    input  ds_allowin, br_bus, inst_sram_rdata,
    output fs_to_ds_valid, fs_to_ds_bus, inst_sram_en, inst_sram_addr
  );

  modport slave (
    output ds_allowin, br_bus, inst_sram_rdata,
    input  fs_to_ds_valid, fs_to_ds_bus, inst_sram_en, inst_sram_addr
  );
endinterface

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: sync-read SRAM request, one-entry holding buffer, ID handoff.
// Define IFETCH_BTFN_EN to enable static backward-taken/forward-not-taken branch predecode.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic          clk,
  input  logic          reset,
  ifetch_stage_if.master bus
);

  logic        fs_valid;
  logic [31:0] fs_pc;
  logic        rdata_fresh;
  logic        buf_valid;
  logic [31:0] inst_buf;

  logic        redirect;
  logic [31:0] jump_target;
  logic        fs_allowin;
  logic        sram_en;
  logic        handoff;
  logic        stall_capture;
  logic [31:0] fs_inst;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic        pred_taken;
  logic [31:0] pred_target;

  assign redirect    = bus.br_bus[32];
  assign jump_target = bus.br_bus[31:0];
  assign fs_allowin  = !fs_valid || bus.ds_allowin || redirect;
  assign sram_en     = !reset && fs_allowin;
  assign fs_inst     = buf_valid ? inst_buf : bus.inst_sram_rdata;
  assign seq_pc      = fs_pc + 32'd4;

`ifdef IFETCH_BTFN_EN
  logic [5:0]  opcode;
  logic        is_b;
  logic        is_cond;
  logic [31:0] b_offs;
  logic [31:0] cond_offs;

  assign opcode     = fs_inst[31:26];
  assign is_b       = (opcode == 6'b010100) || (opcode == 6'b010101);
  assign is_cond    = (opcode >= 6'b010110) && (opcode <= 6'b011011);
  assign b_offs     = {{4{fs_inst[9]}}, fs_inst[9:0], fs_inst[25:10], 2'b00};
  assign cond_offs  = {{14{fs_inst[25]}}, fs_inst[25:10], 2'b00};
  // Conditional branches are predicted taken only when they jump backwards.
  assign pred_taken  = is_b || (is_cond && fs_inst[25]);
  assign pred_target = fs_pc + (is_b ? b_offs : cond_offs);
`else
  assign pred_taken  = 1'b0;
  assign pred_target = seq_pc;
`endif

  // Redirect suppresses the handoff, so the fetched instruction never reaches ID.
  assign bus.fs_to_ds_valid = fs_valid && !redirect;
  assign handoff            = bus.fs_to_ds_valid && bus.ds_allowin;
  assign stall_capture      = fs_valid && rdata_fresh && !bus.ds_allowin && !redirect;

  always_comb begin
    nextpc = seq_pc;
    if (redirect)
      nextpc = jump_target;
    else if (handoff && pred_taken)
      nextpc = pred_target;
  end

  assign bus.inst_sram_en   = sram_en;
  assign bus.inst_sram_addr = nextpc;
  assign bus.fs_to_ds_bus   = {pred_taken, fs_inst, fs_pc};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_valid    <= 1'b0;
      fs_pc       <= RESET_PC - 32'd4;
      rdata_fresh <= 1'b0;
      buf_valid   <= 1'b0;
      inst_buf    <= '0;
    end else begin
      rdata_fresh <= sram_en;
      if (sram_en) begin
        fs_valid  <= 1'b1;
        fs_pc     <= nextpc;
        buf_valid <= 1'b0;
      end else begin
        if (handoff)
          fs_valid <= 1'b0;
        // SRAM data is only valid one cycle after the request; park it while ID stalls.
        if (stall_capture) begin
          inst_buf  <= bus.inst_sram_rdata;
          buf_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed testbench for ifetch_stage: sequential fetch, stall buffering, redirects, async reset,
// and (with IFETCH_BTFN_EN) the static branch predictor.
module tb_ifetch_stage;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  ifetch_stage_if bus ();

  ifetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM contents: a few hand-placed branches, recognisable filler elsewhere.
  function automatic logic [31:0] inst_of(input logic [31:0] addr);
    case (addr)
      32'h1c000010: inst_of = 32'h50004000;  // B +0x40
      32'h1c000050: inst_of = 32'h5bfff800;  // BEQ -8
      32'h1c000048: inst_of = 32'h58000800;  // BEQ +8
      default:      inst_of = {8'h02, addr[23:0]};
    endcase
  endfunction

  // Sync-read SRAM: returns garbage for cycles with no request.
  always @(posedge clk) begin
    if (bus.inst_sram_en)
      bus.inst_sram_rdata <= inst_of(bus.inst_sram_addr);
    else
      bus.inst_sram_rdata <= 32'hbad00000 | 32'($urandom_range(0, 65535));
  end

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the negedge, then check outputs before the next posedge.
  task automatic step(input logic allow, input logic [32:0] br,
                      input logic exp_valid, input logic [31:0] exp_pc, input logic exp_jump,
                      input logic exp_en, input logic [31:0] exp_addr);
    @(negedge clk);
    bus.ds_allowin = allow;
    bus.br_bus     = br;
    #1;
    check("fs_to_ds_valid", 65'(bus.fs_to_ds_valid), 65'(exp_valid));
    if (exp_valid) begin
      check("pc",      65'(bus.fs_to_ds_bus[31:0]),  65'(exp_pc));
      check("inst",    65'(bus.fs_to_ds_bus[63:32]), 65'(inst_of(exp_pc)));
      check("is_jump", 65'(bus.fs_to_ds_bus[64]),    65'(exp_jump));
    end
    check("inst_sram_en", 65'(bus.inst_sram_en), 65'(exp_en));
    if (exp_en)
      check("inst_sram_addr", 65'(bus.inst_sram_addr), 65'(exp_addr));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 65'(bus.fs_to_ds_valid), 65'(0));
    check({tag, "_en"},    65'(bus.inst_sram_en),    65'(0));
  endtask

  task automatic release_reset;
    @(negedge clk);
    reset          = 1'b0;
    bus.ds_allowin = 1'b1;
    bus.br_bus     = '0;
    #1;
    check("rel_valid", 65'(bus.fs_to_ds_valid), 65'(0));
    check("rel_en",    65'(bus.inst_sram_en),   65'(1));
    check("rel_addr",  65'(bus.inst_sram_addr), 65'(32'h1c000000));
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b1;
    bus.ds_allowin = 1'b1;
    bus.br_bus     = '0;
    repeat (2) @(negedge clk);
    #1;
    check_idle("reset");

    // Sequential fetch straight out of reset
    release_reset();
    step(1'b1, 33'h0, 1'b1, 32'h1c000000, 1'b0, 1'b1, 32'h1c000004);
    step(1'b1, 33'h0, 1'b1, 32'h1c000004, 1'b0, 1'b1, 32'h1c000008);

    // ID stalls for three cycles; SRAM returns garbage meanwhile
    step(1'b0, 33'h0, 1'b1, 32'h1c000008, 1'b0, 1'b0, 32'h0);
    step(1'b0, 33'h0, 1'b1, 32'h1c000008, 1'b0, 1'b0, 32'h0);
    step(1'b0, 33'h0, 1'b1, 32'h1c000008, 1'b0, 1'b0, 32'h0);

    // Redirect during the stall: kill, fetch target at once
    step(1'b0, {1'b1, 32'h1c000100}, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1c000100);
    step(1'b1, 33'h0, 1'b1, 32'h1c000100, 1'b0, 1'b1, 32'h1c000104);

    // Redirect in the same cycle ID would accept: no handoff, fetch target
    step(1'b1, {1'b1, 32'h1c000200}, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1c000200);
    step(1'b1, 33'h0, 1'b1, 32'h1c000200, 1'b0, 1'b1, 32'h1c000204);

    // Stall long enough to fill the buffer, then reset mid-stall
    step(1'b0, 33'h0, 1'b1, 32'h1c000204, 1'b0, 1'b0, 32'h0);
    step(1'b0, 33'h0, 1'b1, 32'h1c000204, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_idle("midreset");
    @(negedge clk);
    #1;
    check_idle("midreset_hold");

    // Restart from RESET_PC and run into the branch area
    release_reset();
    step(1'b1, 33'h0, 1'b1, 32'h1c000000, 1'b0, 1'b1, 32'h1c000004);
    step(1'b1, 33'h0, 1'b1, 32'h1c000004, 1'b0, 1'b1, 32'h1c000008);
    step(1'b1, 33'h0, 1'b1, 32'h1c000008, 1'b0, 1'b1, 32'h1c00000c);
    step(1'b1, 33'h0, 1'b1, 32'h1c00000c, 1'b0, 1'b1, 32'h1c000010);
`ifdef IFETCH_BTFN_EN
    step(1'b1, 33'h0, 1'b1, 32'h1c000010, 1'b1, 1'b1, 32'h1c000050);
    step(1'b1, 33'h0, 1'b1, 32'h1c000050, 1'b1, 1'b1, 32'h1c000048);
    step(1'b1, 33'h0, 1'b1, 32'h1c000048, 1'b0, 1'b1, 32'h1c00004c);
    step(1'b1, 33'h0, 1'b1, 32'h1c00004c, 1'b0, 1'b1, 32'h1c000050);
`else
    step(1'b1, 33'h0, 1'b1, 32'h1c000010, 1'b0, 1'b1, 32'h1c000014);
    step(1'b1, 33'h0, 1'b1, 32'h1c000014, 1'b0, 1'b1, 32'h1c000018);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
